// File: rtl/blink_decoder.sv
// Receive side of a blinker link: recovers one pulse per toggle of s_i, measures the
// toggle-to-toggle period and flags a stall when toggles stop arriving.
module blink_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               system1000,
    input  logic               system1000_rst,
    input  logic               s_i,
    output logic               pulse_o,
    output logic [CNT_W-1:0]   period_o,
    output logic               period_valid_o,
    output logic               stalled_o,
    output logic [COUNT_W-1:0] toggle_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_TRACKING,
        ST_STALLED
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_s_prev;
    logic               r_pulse;
    logic [CNT_W-1:0]   r_period;
    logic               r_period_valid;
    logic               r_stalled;
    logic               w_stalled_nxt;
    logic [COUNT_W-1:0] r_toggle_count;
    logic               w_s_sync;
    logic               w_tog;
    logic               w_timeout;
    logic               w_capture;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s_sync = s_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge system1000) begin
                if (system1000_rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= (r_sync << 1) | SYNC_STAGES'(s_i);
                end
            end
            assign w_s_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_tog     = w_s_sync ^ r_s_prev;
    assign w_timeout = (r_cnt == LP_LAST);

    // A toggle always wins over a coincident timeout, so an interval of exactly TIMEOUT is valid.
    always_comb begin
        w_state_nxt   = r_state;
        w_stalled_nxt = r_stalled;
        w_capture     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_tog) w_state_nxt = ST_ARMED;
            end
            ST_ARMED, ST_TRACKING: begin
                if (w_tog) begin
                    w_state_nxt = ST_TRACKING;
                    w_capture   = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt   = ST_STALLED;
                    w_stalled_nxt = 1'b1;
                end
            end
            ST_STALLED: begin
                if (w_tog) begin
                    w_state_nxt   = ST_ARMED;
                    w_stalled_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_tog) begin
            w_cnt_nxt = '0;
        end else if ((r_state == ST_ARMED || r_state == ST_TRACKING) && !w_timeout) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_s_prev       <= 1'b0;
            r_pulse        <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b0;
            r_toggle_count <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_s_prev       <= w_s_sync;
            r_pulse        <= w_tog;
            r_period_valid <= w_capture;
            r_stalled      <= w_stalled_nxt;
            if (w_capture) r_period <= r_cnt + 1'b1;
            if (w_tog) r_toggle_count <= r_toggle_count + 1'b1;
        end
    end

    assign pulse_o        = r_pulse;
    assign period_o       = r_period;
    assign period_valid_o = r_period_valid;
    assign stalled_o      = r_stalled;
    assign toggle_count_o = r_toggle_count;

endmodule

// File: tb/tb_blink_decoder.sv
// Bench for blink_decoder: segment table driven through a timestamp-based scoreboard model,
// plus hand-written sequences pinning exact edge timings.
module tb_blink_decoder;

    localparam int unsigned SYNC    = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned COUNT_W = 4;

    logic               clk;
    logic               rst;
    logic               s;
    logic               pulse_o;
    logic [CNT_W-1:0]   period_o;
    logic               period_valid_o;
    logic               stalled_o;
    logic [COUNT_W-1:0] toggle_count_o;

    blink_decoder #(
        .SYNC_STAGES(SYNC),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .COUNT_W    (COUNT_W)
    ) dut (
        .system1000    (clk),
        .system1000_rst(rst),
        .s_i           (s),
        .pulse_o       (pulse_o),
        .period_o      (period_o),
        .period_valid_o(period_valid_o),
        .stalled_o     (stalled_o),
        .toggle_count_o(toggle_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic               pulse;
        logic               pv;
        logic [CNT_W-1:0]   period;
        logic               stalled;
        logic [COUNT_W-1:0] count;
    } exp_t;

    typedef struct {
        logic        rst;
        int unsigned every;   // 0 = hold level, else flip s every N cycles
        int unsigned cycles;
    } seg_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: remembers the edge index of the last toggle rather than a counter.
    logic [SYNC-1:0]    m_h;
    logic               m_prev;
    logic               m_active;
    logic               m_stalled;
    logic [CNT_W-1:0]   m_period;
    logic [COUNT_W-1:0] m_count;
    int                 m_edge = 0;
    int                 m_last = 0;

    task automatic model_edge(input logic r, input logic si);
        exp_t x;
        logic tog;
        logic pv;
        m_edge++;
        if (r) begin
            m_h       = '0;
            m_prev    = 1'b0;
            m_active  = 1'b0;
            m_stalled = 1'b0;
            m_period  = '0;
            m_count   = '0;
            x = '{pulse: 1'b0, pv: 1'b0, period: '0, stalled: 1'b0, count: '0};
        end else begin
            tog    = m_h[SYNC-1] ^ m_prev;
            m_prev = m_h[SYNC-1];
            m_h    = {m_h[SYNC-2:0], si};
            pv     = 1'b0;
            if (tog) begin
                m_count = m_count + 1'b1;
                if (m_active) begin
                    m_period = CNT_W'(m_edge - m_last);
                    pv       = 1'b1;
                end
                m_active  = 1'b1;
                m_stalled = 1'b0;
                m_last    = m_edge;
            end else if (m_active && (m_edge - m_last) == int'(TIMEOUT)) begin
                m_stalled = 1'b1;
                m_active  = 1'b0;
            end
            x = '{pulse: tog, pv: pv, period: m_period, stalled: m_stalled, count: m_count};
        end
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    task automatic step(input logic r, input logic si);
        exp_t x;
        exp_t g;
        rst = r;
        s   = si;
        model_edge(r, si);
        @(posedge clk);
        @(negedge clk);
        g = '{pulse: pulse_o, pv: period_valid_o, period: period_o,
              stalled: stalled_o, count: toggle_count_o};
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: got output with empty queue at t=%0t", $time);
        end else begin
            x = sb.pop_front();
            if (g == x) n_pass++;
            else $display("FAIL sb t=%0t: got p=%0b v=%0b per=%0d st=%0b cnt=%0d expected p=%0b v=%0b per=%0d st=%0b cnt=%0d",
                          $time, g.pulse, g.pv, g.period, g.stalled, g.count,
                          x.pulse, x.pv, x.period, x.stalled, x.count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_t segs[11];
        int   e;
        logic sv;

        segs[0]  = '{rst: 1'b1, every: 0, cycles: 3};
        segs[1]  = '{rst: 1'b0, every: 0, cycles: 50};
        segs[2]  = '{rst: 1'b0, every: 5, cycles: 40};
        segs[3]  = '{rst: 1'b0, every: 1, cycles: 20};
        segs[4]  = '{rst: 1'b0, every: 0, cycles: 20};
        segs[5]  = '{rst: 1'b0, every: 3, cycles: 9};
        segs[6]  = '{rst: 1'b0, every: 8, cycles: 40};
        segs[7]  = '{rst: 1'b0, every: 9, cycles: 30};
        segs[8]  = '{rst: 1'b0, every: 2, cycles: 12};
        segs[9]  = '{rst: 1'b1, every: 0, cycles: 2};
        segs[10] = '{rst: 1'b0, every: 0, cycles: 10};

        rst = 1'b1;
        s   = 1'b0;
        sv  = 1'b0;
        for (int k = 0; k < 11; k++) begin
            for (int unsigned i = 0; i < segs[k].cycles; i++) begin
                if (segs[k].every != 0 && (i % segs[k].every) == 0) sv = ~sv;
                step(segs[k].rst, sv);
            end
            if (k == 1) begin
                chk("idle_pulse", pulse_o, 0);
                chk("idle_stalled", stalled_o, 0);
                chk("idle_count", toggle_count_o, 0);
            end
        end

        // First toggle sampled at edge 10 -> pulse after edge 12; stall 8 edges later.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (e = 1; e <= 22; e++) begin
            step(1'b0, e >= 10);
            chk("first_pulse_edge", pulse_o, (e == 12) ? 1 : 0);
            chk("first_no_valid", period_valid_o, 0);
            chk("stall_rise", stalled_o, (e >= 20) ? 1 : 0);
        end
        chk("first_count", toggle_count_o, 1);
        for (e = 23; e <= 25; e++) step(1'b0, 1'b0);
        chk("unstall_pulse", pulse_o, 1);
        chk("unstall_clear", stalled_o, 0);
        chk("unstall_no_valid", period_valid_o, 0);
        for (e = 26; e <= 28; e++) step(1'b0, 1'b1);
        chk("period3_valid", period_valid_o, 1);
        chk("period3_value", period_o, 3);

        // Toggles exactly TIMEOUT edges apart never stall.
        sv = 1'b1;
        for (e = 29; e <= 60; e++) begin
            if (e % 8 == 2) sv = ~sv;
            step(1'b0, sv);
            chk("tmo_edge_stall", stalled_o, 0);
            chk("tmo_edge_valid", period_valid_o, (e >= 36 && e % 8 == 4) ? 1 : 0);
            if (e >= 36 && e % 8 == 4) chk("tmo_edge_period", period_o, 8);
        end

        // Reset mid-tracking with s_i held high.
        step(1'b1, 1'b1);
        chk("rst_pulse", pulse_o, 0);
        chk("rst_valid", period_valid_o, 0);
        chk("rst_stalled", stalled_o, 0);
        chk("rst_period", period_o, 0);
        chk("rst_count", toggle_count_o, 0);
        for (int r = 1; r <= 6; r++) begin
            step(1'b0, 1'b1);
            chk("post_rst_pulse", pulse_o, (r == 3) ? 1 : 0);
            chk("post_rst_valid", period_valid_o, 0);
        end
        chk("post_rst_count", toggle_count_o, 1);

        // 17 toggles wrap the 4-bit toggle counter through 0 to 1.
        step(1'b1, 1'b0);
        sv = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            sv = ~sv;
            step(1'b0, sv);
        end
        for (int h = 1; h <= 4; h++) begin
            step(1'b0, sv);
            if (h == 1) chk("wrap_zero", toggle_count_o, 0);
            if (h >= 2) chk("wrap_one", toggle_count_o, 1);
        end

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
